hamming_tmr_serializer: RTL and testbench

Transmit-side counterpart of the TMR/Hamming(7,4) vote-and-decode path. Accepts a 4-bit data word over a valid/ready handshake and encodes it to a Hamming(7,4) codeword. It then drives that codeword serially and simultaneously on three replicated single-bit lanes, which feed the downstream TMR voter/decoder after deserialization. A per-frame fault-injection control corrupts one bit on one lane so the voter/corrector path can be exercised in system.

---
 rtl/hamming_tmr_pkg.sv | 30 +++
 rtl/hamming_lane_shifter.sv | 36 +++
 rtl/hamming_tmr_serializer.sv | 125 ++++++++++++
 tb/tb_hamming_tmr_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_tmr_pkg.sv
// Shared Hamming(7,4) definitions for the TMR transmit and receive paths.
// Both ends use the same encoder function, so a mapping change affects both.
package hamming_tmr_pkg;

    localparam int CW_BITS    = 7;
    localparam int FRAME_BITS = 9;

    typedef logic [CW_BITS-1:0] codeword_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Parity bits sit at cw[6], cw[5] and cw[3]; data bits occupy the remaining positions.
    function automatic codeword_t hamming74_enc(input logic [3:0] data);
        codeword_t cw;
        cw[0] = data[0];
        cw[1] = data[1];
        cw[2] = data[2];
        cw[3] = data[2] ^ data[1] ^ data[0];
        cw[4] = data[3];
        cw[5] = data[3] ^ data[1] ^ data[0];
        cw[6] = data[3] ^ data[2] ^ data[0];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_lane_shifter.sv
// One replica lane: holds a codeword and shifts it out LSB first.
// The head bit is the next data bit that the top level will register onto the line.
module hamming_lane_shifter
    import hamming_tmr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      shift_i,
    input  codeword_t load_data_i,
    output logic      head_o
);

    codeword_t shiftReg_q;
    codeword_t shiftReg_d;

    always_comb begin
        shiftReg_d = shiftReg_q;
        if (load_i) begin
            shiftReg_d = load_data_i;
        end else if (shift_i) begin
            shiftReg_d = {1'b0, shiftReg_q[CW_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg_q <= '0;
        end else begin
            shiftReg_q <= shiftReg_d;
        end
    end

    assign head_o = shiftReg_q[0];

endmodule

// File: rtl/hamming_tmr_serializer.sv
// Hamming(7,4) encoder driving three replicated serial lanes for a downstream TMR voter.
// One shared FSM times the frame; each lane can carry a single injected bit flip.
module hamming_tmr_serializer
    import hamming_tmr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       inj_en,
    input  logic [1:0] inj_lane,
    input  logic [2:0] inj_bit,
    output logic [2:0] tx_lane,
    output logic       tx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0] bitIdx_q;
    logic       inReady_q;
    logic       txBusy_q;
    logic [2:0] txLane_q;

    logic       transfer;
    logic       tick;
    logic       shiftEn;
    logic       injActive;
    codeword_t  cleanCw;
    codeword_t  injMask;
    logic [2:0] heads;

    assign transfer  = (state_q == IDLE) && in_valid && inReady_q;
    assign tick      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign shiftEn   = tick && ((state_q == START) || (state_q == DATA));
    assign injActive = inj_en && (inj_lane != 2'd3) && (inj_bit != 3'd7);
    assign cleanCw   = hamming74_enc(in_data);
    assign injMask   = codeword_t'(1) << inj_bit;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        codeword_t laneData;
        assign laneData = (injActive && (inj_lane == 2'(g))) ? (cleanCw ^ injMask) : cleanCw;

        hamming_lane_shifter u_shifter (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (transfer),
            .shift_i     (shiftEn),
            .load_data_i (laneData),
            .head_o      (heads[g])
        );
    end

    // Frame sequencer; every output is registered here so nothing on an input reaches a pin combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            inReady_q <= 1'b0;
            txBusy_q  <= 1'b0;
            txLane_q  <= 3'b111;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    bitIdx_q <= '0;
                    if (transfer) begin
                        state_q   <= START;
                        inReady_q <= 1'b0;
                        txBusy_q  <= 1'b1;
                        txLane_q  <= 3'b000;
                    end else begin
                        inReady_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt_q    <= '0;
                        state_q  <= DATA;
                        txLane_q <= heads;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q <= '0;
                        if (bitIdx_q == 3'(CW_BITS - 1)) begin
                            state_q  <= STOP;
                            txLane_q <= 3'b111;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            txLane_q <= heads;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        inReady_q <= 1'b1;
                        txBusy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = inReady_q;
    assign tx_busy  = txBusy_q;
    assign tx_lane  = txLane_q;

endmodule

// File: tb/tb_hamming_tmr_serializer.sv
// Drives two serializers (4 and 1 clocks per bit) with shared stimulus and
// compares every cycle of each frame against a per-lane bit-list model.
module tb_hamming_tmr_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       inj_en;
    logic [1:0] inj_lane;
    logic [2:0] inj_bit;

    logic       rdy4, busy4, rdy1, busy1;
    logic [2:0] lane4, lane1;

    int total = 0;
    int bad   = 0;

    logic expFrame [0:2][0:8];

    always #5 clk = ~clk;

    hamming_tmr_serializer #(.CLKS_PER_BIT(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (rdy4),
        .inj_en   (inj_en),
        .inj_lane (inj_lane),
        .inj_bit  (inj_bit),
        .tx_lane  (lane4),
        .tx_busy  (busy4)
    );

    hamming_tmr_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (rdy1),
        .inj_en   (inj_en),
        .inj_lane (inj_lane),
        .inj_bit  (inj_bit),
        .tx_lane  (lane1),
        .tx_busy  (busy1)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] refCodeword(input logic [3:0] d);
        int par6, par5, par3;
        par6 = (d[3] + d[2] + d[0]) % 2;
        par5 = (d[3] + d[1] + d[0]) % 2;
        par3 = (d[2] + d[1] + d[0]) % 2;
        return {par6[0], par5[0], d[3], par3[0], d[2], d[1], d[0]};
    endfunction

    task automatic buildModel(input logic [3:0] d, input logic e, input logic [1:0] l, input logic [2:0] b);
        logic [6:0] cw;
        logic [6:0] w;
        cw = refCodeword(d);
        for (int ln = 0; ln < 3; ln++) begin
            w = cw;
            if (e && l <= 2 && b <= 6 && int'(l) == ln) w[b] = ~w[b];
            expFrame[ln][0] = 1'b0;
            for (int k = 0; k < 7; k++) expFrame[ln][k+1] = w[k];
            expFrame[ln][8] = 1'b1;
        end
    endtask

    function automatic logic [2:0] expLane(input int t, input int cpb);
        logic [2:0] r;
        r = 3'b111;
        if (t < 9 * cpb) begin
            for (int ln = 0; ln < 3; ln++) r[ln] = expFrame[ln][t / cpb];
        end
        return r;
    endfunction

    task automatic checkFrame(input bit withC1, input int lastT);
        for (int t = 0; t <= lastT; t++) begin
            @(negedge clk);
            checkOutput($sformatf("lane4@%0d", t), {5'b0, lane4}, {5'b0, expLane(t, 4)});
            checkOutput($sformatf("busy4@%0d", t), {7'b0, busy4}, {7'b0, (t < 36)});
            checkOutput($sformatf("ready4@%0d", t), {7'b0, rdy4}, {7'b0, (t >= 36)});
            if (withC1) begin
                checkOutput($sformatf("lane1@%0d", t), {5'b0, lane1}, {5'b0, expLane(t, 1)});
                checkOutput($sformatf("busy1@%0d", t), {7'b0, busy1}, {7'b0, (t < 9)});
                checkOutput($sformatf("ready1@%0d", t), {7'b0, rdy1}, {7'b0, (t >= 9)});
            end
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!(rdy4 && rdy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("readyTimeout", 8'd0, 8'd1);
    endtask

    // Presents one word, then scrambles the inputs so a late capture would show up.
    task automatic applyStimulus(input logic [3:0] d, input logic e, input logic [1:0] l, input logic [2:0] b);
        waitReady();
        in_valid = 1'b1;
        in_data  = d;
        inj_en   = e;
        inj_lane = l;
        inj_bit  = b;
        @(posedge clk);
        buildModel(d, e, l, b);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        inj_en   = 1'($urandom);
        inj_lane = 2'($urandom);
        inj_bit  = 3'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_valid = 1'b0;
        in_data  = 4'h0;
        inj_en   = 1'b0;
        inj_lane = 2'd3;
        inj_bit  = 3'd7;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstLane4", {5'b0, lane4}, 8'h07);
        checkOutput("rstBusy4", {7'b0, busy4}, 8'h00);
        checkOutput("rstReady4", {7'b0, rdy4}, 8'h00);
        checkOutput("rstLane1", {5'b0, lane1}, 8'h07);
        rst_n = 1'b1;
        #1 checkOutput("readyBeforeEdge", {7'b0, rdy4}, 8'h00);
        @(negedge clk);
        checkOutput("readyAfterEdge4", {7'b0, rdy4}, 8'h01);
        checkOutput("readyAfterEdge1", {7'b0, rdy1}, 8'h01);

        applyStimulus(4'b1011, 1'b0, 2'd3, 3'd7);
        checkFrame(1'b1, 36);
        applyStimulus(4'b1011, 1'b1, 2'd1, 3'd4);
        checkFrame(1'b1, 36);
        applyStimulus(4'b1011, 1'b0, 2'd1, 3'd4);
        checkFrame(1'b1, 36);
        applyStimulus(4'hF, 1'b0, 2'd0, 3'd0);
        checkFrame(1'b1, 36);
        applyStimulus(4'h6, 1'b1, 2'd3, 3'd2);
        checkFrame(1'b1, 36);
        applyStimulus(4'h9, 1'b1, 2'd0, 3'd7);
        checkFrame(1'b1, 36);

        // Back-to-back with in_valid held; only the slow instance is checked here.
        waitReady();
        in_valid = 1'b1;
        in_data  = 4'h0;
        inj_en   = 1'b0;
        @(posedge clk);
        buildModel(4'h0, 1'b0, 2'd3, 3'd7);
        #1 in_data = 4'hF;
        checkFrame(1'b0, 36);
        buildModel(4'hF, 1'b0, 2'd3, 3'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'h5;
        checkFrame(1'b0, 36);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            checkFrame(1'b1, 36);
        end

        // Reset while the slow instance is in data bit 3.
        applyStimulus(4'hA, 1'b0, 2'd3, 3'd7);
        checkFrame(1'b1, 17);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstLane4", {5'b0, lane4}, 8'h07);
        checkOutput("midRstBusy4", {7'b0, busy4}, 8'h00);
        checkOutput("midRstReady4", {7'b0, rdy4}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("midRstReadyLow", {7'b0, rdy4}, 8'h00);
        @(negedge clk);
        checkOutput("midRstReadyHigh", {7'b0, rdy4}, 8'h01);
        applyStimulus(4'h3, 1'b1, 2'd2, 3'd6);
        checkFrame(1'b1, 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
